// File: rtl/win_line_buf_if.sv
// Signal bundle between the raster pixel source, the line buffer and the
// downstream padded window stage.
interface win_line_buf_if #(
  parameter int unsigned FRAME_H_MAX = 224,
  parameter int unsigned FRAME_W_MAX = 224,
  parameter int unsigned DIN_WIDTH   = 8,
  parameter int unsigned WIN_SIZE    = 3,
  parameter int unsigned CH_NUM      = 3
) ();
  localparam int unsigned HW = $clog2(FRAME_H_MAX - 1) + 1;
  localparam int unsigned WW = $clog2(FRAME_W_MAX - 1) + 1;

  logic [HW-1:0]                                  frame_h;
  logic [WW-1:0]                                  frame_w;
  logic                                           frame_start;
  logic                                           din_vld;
  logic [CH_NUM-1:0][DIN_WIDTH-1:0]               din;
  logic                                           din_rdy;
  logic                                           frame_start_o;
  logic                                           dout_vld;
  logic [WIN_SIZE-1:0][CH_NUM-1:0][DIN_WIDTH-1:0] dout;
  logic                                           busy;

  modport master (
    output frame_h, frame_w, frame_start, din_vld, din,
    input  din_rdy, frame_start_o, dout_vld, dout, busy
  );

  modport slave (
    input  frame_h, frame_w, frame_start, din_vld, din,
    output din_rdy, frame_start_o, dout_vld, dout, busy
  );
endinterface

// File: rtl/win_line_buf.sv
// Raster-to-column line buffer: keeps the previous WIN_SIZE-1 rows and emits one
// zero-padded vertical column of WIN_SIZE pixels per frame position.
module win_line_buf #(
  parameter int unsigned FRAME_H_MAX = 224,
  parameter int unsigned FRAME_W_MAX = 224,
  parameter int unsigned DIN_WIDTH   = 8,
  parameter int unsigned WIN_SIZE    = 3,
  parameter int unsigned CH_NUM      = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  win_line_buf_if.slave bus
);
  localparam int unsigned WinR     = WIN_SIZE / 2;
  localparam int unsigned NumLines = WIN_SIZE - 1;
  localparam int unsigned HW       = $clog2(FRAME_H_MAX - 1) + 1;
  localparam int unsigned WW       = $clog2(FRAME_W_MAX - 1) + 1;
  localparam int unsigned RW       = HW + 1;
  localparam int unsigned AW       = (FRAME_W_MAX > 1) ? $clog2(FRAME_W_MAX) : 1;
  localparam int unsigned LW       = $clog2(NumLines);

  typedef logic [CH_NUM-1:0][DIN_WIDTH-1:0] pix_t;
  typedef enum logic [1:0] {StIdle, StPrime, StRun, StFlush} state_e;

  state_e                state_q, state_d;
  logic [HW-1:0]         fh_q, fh_d;
  logic [WW-1:0]         fw_q, fw_d;
  logic [WW-1:0]         col_q, col_d;
  logic [RW-1:0]         row_q, row_d;
  logic [LW-1:0]         wptr_q, wptr_d;
  pix_t [WIN_SIZE-1:0]   dout_q, dout_d;
  logic                  dvld_q, dvld_d;
  logic                  fso_q, fso_d;

  pix_t                  mem_q [NumLines][FRAME_W_MAX];
  logic [LW-1:0]         rd_line [WIN_SIZE];
  pix_t [WIN_SIZE-1:0]   taps;
  logic [AW-1:0]         addr;
  logic [RW-1:0]         row_inc;
  logic                  din_rdy, accept, step, col_last, wr_en;

  assign din_rdy  = (state_q == StPrime) || (state_q == StRun);
  assign accept   = bus.din_vld && din_rdy && !bus.frame_start;
  assign addr     = col_q[AW-1:0];
  assign col_last = (col_q == fw_q - 1'b1);
  assign row_inc  = row_q + 1'b1;

  // Row s lives in line (s mod NumLines); the oldest tap shares the line being
  // written and relies on read-before-write to see the row from NumLines ago.
  always_comb begin
    for (int k = 0; k < WIN_SIZE; k++) begin
      rd_line[k] = LW'((int'(wptr_q) + int'(NumLines) - k) % int'(NumLines));
      taps[k]    = '0;
      if ((int'(row_q) >= k) && (int'(row_q) - k < int'(fh_q))) begin
        if (k == 0) taps[k] = bus.din;
        else        taps[k] = mem_q[rd_line[k]][addr];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    fh_d    = fh_q;
    fw_d    = fw_q;
    col_d   = col_q;
    row_d   = row_q;
    wptr_d  = wptr_q;
    dout_d  = dout_q;
    dvld_d  = 1'b0;
    fso_d   = 1'b0;
    wr_en   = 1'b0;
    step    = 1'b0;

    unique case (state_q)
      StIdle: ;
      StPrime: begin
        wr_en = accept;
        step  = accept;
      end
      StRun: begin
        wr_en = accept;
        step  = accept;
        if (accept) begin
          dout_d = taps;
          dvld_d = 1'b1;
        end
      end
      StFlush: begin
        step = 1'b1;
        // Flush rows above WinR carry real output rows; lower ones only advance.
        if (row_q >= RW'(WinR)) begin
          dout_d = taps;
          dvld_d = 1'b1;
        end
      end
    endcase

    if (step) begin
      if (col_last) begin
        col_d  = '0;
        row_d  = row_inc;
        wptr_d = (wptr_q == LW'(NumLines - 1)) ? '0 : wptr_q + 1'b1;
        case (state_q)
          StPrime: begin
            if ((row_inc >= RW'(WinR)) || (row_inc >= {1'b0, fh_q})) begin
              fso_d   = 1'b1;
              state_d = (row_inc >= {1'b0, fh_q}) ? StFlush : StRun;
            end
          end
          StRun:   if (row_inc == {1'b0, fh_q}) state_d = StFlush;
          StFlush: if (row_inc == {1'b0, fh_q} + RW'(WinR)) state_d = StIdle;
          default: ;
        endcase
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // A new frame_start always wins, aborting whatever frame was in flight.
    if (bus.frame_start) begin
      state_d = StPrime;
      fh_d    = bus.frame_h;
      fw_d    = bus.frame_w;
      col_d   = '0;
      row_d   = '0;
      wptr_d  = '0;
      dvld_d  = 1'b0;
      fso_d   = 1'b0;
      wr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      fh_q    <= '0;
      fw_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      wptr_q  <= '0;
      dout_q  <= '0;
      dvld_q  <= 1'b0;
      fso_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fh_q    <= fh_d;
      fw_q    <= fw_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wptr_q  <= wptr_d;
      dout_q  <= dout_d;
      dvld_q  <= dvld_d;
      fso_q   <= fso_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wptr_q][addr] <= bus.din;
  end

  assign bus.din_rdy       = din_rdy;
  assign bus.frame_start_o = fso_q;
  assign bus.dout_vld      = dvld_q;
  assign bus.dout          = dout_q;
  assign bus.busy          = (state_q != StIdle);
endmodule

// File: tb/tb_win_line_buf.sv
// Bench for win_line_buf: directed and random frames scored against a
// frame-level column model built from the stored input image.
module tb_win_line_buf;
  localparam int FH  = 16;
  localparam int FW  = 16;
  localparam int DW  = 8;
  localparam int WIN = 3;
  localparam int CH  = 2;
  localparam int WR  = WIN / 2;
  localparam int HW  = $clog2(FH - 1) + 1;
  localparam int WW  = $clog2(FW - 1) + 1;

  typedef logic [CH-1:0][DW-1:0] pix_t;
  typedef pix_t [WIN-1:0]        col_t;
  typedef struct {
    col_t col;
    bit   from_acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  win_line_buf_if #(.FRAME_H_MAX(FH), .FRAME_W_MAX(FW), .DIN_WIDTH(DW),
                    .WIN_SIZE(WIN), .CH_NUM(CH)) bus ();

  win_line_buf #(.FRAME_H_MAX(FH), .FRAME_W_MAX(FW), .DIN_WIDTH(DW),
                 .WIN_SIZE(WIN), .CH_NUM(CH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_fail   = 0;
  pix_t img[$];
  int   drv_h, drv_w;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   fso_seen = 1'b0;
  bit   acc_prev = 1'b0;
  int   n_vld    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Column model: output row r, column c, tap k comes from image row r+WR-k.
  function automatic void build_exp();
    exp_t e;
    int   s;
    exp_q.delete();
    for (int r = 0; r < drv_h; r++) begin
      for (int c = 0; c < drv_w; c++) begin
        for (int k = 0; k < WIN; k++) begin
          s = r + WR - k;
          e.col[k] = (s >= 0 && s < drv_h) ? img[s * drv_w + c] : '0;
        end
        e.from_acc = (r + WR < drv_h);
        exp_q.push_back(e);
      end
    end
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.dout_vld) begin
        n_vld++;
        chk("vld_after_fso", 64'(fso_seen), 64'(1));
        chk("vld_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("column", 64'(bus.dout), 64'(mon_e.col));
          if (mon_e.from_acc) chk("latency1", 64'(acc_prev), 64'(1));
        end
      end
      if (bus.frame_start_o) begin
        chk("fso_once", 64'(fso_seen), 64'(0));
        fso_seen = 1'b1;
      end
      acc_prev = bus.din_vld && bus.din_rdy && !bus.frame_start;
      if (bus.frame_start) begin
        build_exp();
        fso_seen = 1'b0;
        n_vld    = 0;
      end
    end
  end

  // Entered and left at posedge+1 so every input change sits away from the edge.
  task automatic start_frame(input int h, input int w, input bit rnd, input bit coinc);
    pix_t p;
    img.delete();
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        for (int ch = 0; ch < CH; ch++)
          p[ch] = rnd ? DW'($urandom_range(0, 254)) : DW'(r * 16 + c + ch * 64);
        img.push_back(p);
      end
    end
    drv_h = h;
    drv_w = w;
    bus.frame_h     = HW'(h);
    bus.frame_w     = WW'(w);
    bus.frame_start = 1'b1;
    bus.din_vld     = coinc;
    bus.din         = '1;
    @(posedge clk); #1;
    bus.frame_start = 1'b0;
    bus.din_vld     = 1'b0;
  endtask

  // vld_mode: 0 back-to-back, 1 alternate, 2 random.
  task automatic feed(input int npix, input int vld_mode);
    int idx = 0;
    int cyc = 0;
    bit ph  = 1'b1;
    while (idx < npix && cyc < 4000) begin
      bus.din_vld = (vld_mode == 0) ? 1'b1 : (vld_mode == 1) ? ph : 1'($urandom_range(0, 1));
      bus.din     = img[idx];
      ph = ~ph;
      @(negedge clk);
      if (bus.din_vld && bus.din_rdy) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.din_vld = 1'b0;
    chk("feed_done", 64'(idx), 64'(npix));
  endtask

  task automatic wait_idle(input int h, input int w, input bit junk);
    int cyc = 0;
    if (junk) begin
      bus.din_vld = 1'b1;
      bus.din     = '1;
    end
    @(negedge clk);
    while (bus.busy && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk); #1;
    bus.din_vld = 1'b0;
    chk("idle", 64'(bus.busy), 64'(0));
    chk("rdy_idle", 64'(bus.din_rdy), 64'(0));
    chk("drained", 64'(exp_q.size()), 64'(0));
    chk("vld_count", 64'(n_vld), 64'(h * w));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n         = 1'b0;
    bus.frame_h     = '0;
    bus.frame_w     = '0;
    bus.frame_start = 1'b0;
    bus.din_vld     = 1'b0;
    bus.din         = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_rdy", 64'(bus.din_rdy), 64'(0));
    chk("rst_vld", 64'(bus.dout_vld), 64'(0));
    chk("rst_fso", 64'(bus.frame_start_o), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_dout", 64'(bus.dout), 64'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 4x4 pattern frame, back-to-back then alternating valid
    start_frame(4, 4, 1'b0, 1'b0);
    feed(16, 0);
    wait_idle(4, 4, 1'b0);
    start_frame(4, 4, 1'b0, 1'b0);
    feed(16, 1);
    wait_idle(4, 4, 1'b0);

    // abort in RUN at row 2 col 1, then a fresh 3x2 frame
    start_frame(4, 4, 1'b0, 1'b0);
    feed(9, 0);
    start_frame(3, 2, 1'b1, 1'b0);
    feed(6, 0);
    wait_idle(3, 2, 1'b0);

    // pixel coincident with frame_start is dropped; junk ignored while not ready
    start_frame(2, 3, 1'b0, 1'b1);
    feed(6, 0);
    wait_idle(2, 3, 1'b1);

    // short and narrow frames
    start_frame(1, 5, 1'b1, 1'b0);
    feed(5, 1);
    wait_idle(1, 5, 1'b0);
    start_frame(5, 1, 1'b1, 1'b0);
    feed(5, 2);
    wait_idle(5, 1, 1'b0);

    for (int i = 0; i < 5; i++) begin
      int h, w;
      h = $urandom_range(1, 8);
      w = $urandom_range(1, 10);
      start_frame(h, w, 1'b1, 1'b0);
      feed(h * w, 2);
      wait_idle(h, w, 1'b0);
    end

    // asynchronous reset while flushing
    start_frame(3, 4, 1'b1, 1'b0);
    feed(12, 0);
    chk("flush_busy", 64'(bus.busy), 64'(1));
    chk("flush_rdy", 64'(bus.din_rdy), 64'(0));
    @(posedge clk); #2;
    chk("flush_vld", 64'(bus.dout_vld), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("arst_vld", 64'(bus.dout_vld), 64'(0));
    chk("arst_dout", 64'(bus.dout), 64'(0));
    chk("arst_busy", 64'(bus.busy), 64'(0));
    chk("arst_fso", 64'(bus.frame_start_o), 64'(0));
    exp_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    start_frame(4, 3, 1'b1, 1'b0);
    feed(12, 2);
    wait_idle(4, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
